// File: rtl/spi_frame_capture.sv
// Passive SPI frame sniffer. It oversamples the SPI pins on clk, captures one frame per
// chip-select assertion and presents it on a valid/ready port.
module spi_frame_capture #(
    parameter int NUM_CS   = 8,
    parameter int MAX_BITS = 128,
    parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk,
    input  logic [NUM_CS-1:0]   cs_n,
    input  logic                mosi,
    input  logic                miso,
    input  logic                cpol,
    input  logic                cpha,
    output logic                frm_valid,
    input  logic                frm_ready,
    output logic [MAX_BITS-1:0] frm_mosi,
    output logic [MAX_BITS-1:0] frm_miso,
    output logic [CNT_W-1:0]    frm_bits,
    output logic [NUM_CS-1:0]   frm_cs,
    output logic                frm_ovf,
    output logic                frm_err,
    output logic [7:0]          drop_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic [NUM_CS-1:0] r_cs_s1, r_cs_s2;
    logic              r_mosi_s1, r_mosi_s2, r_miso_s1, r_miso_s2;

    logic [1:0]          r_state;
    logic                r_cpol, r_cpha;
    logic [NUM_CS-1:0]   r_cs;
    logic [MAX_BITS-1:0] r_sh_mosi, r_sh_miso;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf, r_err;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its neighbours and the synchronizer chains stay real chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_cs_s1   <= '1;
            r_cs_s2   <= '1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    logic              w_rise, w_fall, w_lead, w_trail, w_sample;
    logic [NUM_CS-1:0] w_cs_act;
    logic              w_cs_idle;

    assign w_rise    = r_sclk_s2 & ~r_sclk_d;
    assign w_fall    = ~r_sclk_s2 & r_sclk_d;
    assign w_lead    = r_cpol ? w_fall : w_rise;
    assign w_trail   = r_cpol ? w_rise : w_fall;
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_cs_act  = ~r_cs_s2;
    assign w_cs_idle = (w_cs_act == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_cs      <= '0;
            r_sh_mosi <= '0;
            r_sh_miso <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_cs_idle) begin
                        r_state   <= S_ACTIVE;
                        r_cpol    <= cpol;
                        r_cpha    <= cpha;
                        r_cs      <= w_cs_act;
                        r_sh_mosi <= '0;
                        r_sh_miso <= '0;
                        r_cnt     <= '0;
                        r_ovf     <= 1'b0;
                        r_err     <= ($countones(w_cs_act) > 1) || (r_sclk_s2 != cpol);
                    end
                end
                S_ACTIVE: begin
                    // A closing sample edge in the release cycle is still captured.
                    if (w_sample) begin
                        r_sh_mosi <= {r_sh_mosi[MAX_BITS-2:0], r_mosi_s2};
                        r_sh_miso <= {r_sh_miso[MAX_BITS-2:0], r_miso_s2};
                        if (r_cnt == CNT_W'(MAX_BITS)) r_ovf <= 1'b1;
                        else                           r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_cs_idle)                r_state <= S_DONE;
                    else if (w_cs_act != r_cs)    r_err   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_done, w_busy, w_push, w_drop;

    assign w_done = (r_state == S_DONE) && (r_cnt != '0);
    assign w_busy = frm_valid && !frm_ready;
    assign w_push = w_done && !w_busy;
    assign w_drop = w_done && w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_valid <= 1'b0;
            frm_mosi  <= '0;
            frm_miso  <= '0;
            frm_bits  <= '0;
            frm_cs    <= '0;
            frm_ovf   <= 1'b0;
            frm_err   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (w_push) begin
                frm_valid <= 1'b1;
                frm_mosi  <= r_sh_mosi;
                frm_miso  <= r_sh_miso;
                frm_bits  <= r_cnt;
                frm_cs    <= r_cs;
                frm_ovf   <= r_ovf;
                frm_err   <= r_err;
            end else if (frm_valid && frm_ready) begin
                frm_valid <= 1'b0;
            end
            if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_frame_capture.sv
// Directed bench for spi_frame_capture: a vector table of whole frames plus hand-written
// sequences for back-pressure/drop, empty CS pulse and mid-frame reset.
module tb_spi_frame_capture;

    localparam int NUM_CS   = 8;
    localparam int MAX_BITS = 128;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sclk = 1'b0;
    logic [NUM_CS-1:0]   cs_n = '1;
    logic                mosi = 1'b0;
    logic                miso = 1'b0;
    logic                cpol = 1'b0;
    logic                cpha = 1'b0;
    logic                frm_ready = 1'b0;
    logic                frm_valid;
    logic [MAX_BITS-1:0] frm_mosi, frm_miso;
    logic [CNT_W-1:0]    frm_bits;
    logic [NUM_CS-1:0]   frm_cs;
    logic                frm_ovf, frm_err;
    logic [7:0]          drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_frame_capture #(.NUM_CS(NUM_CS), .MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .cpol(cpol), .cpha(cpha), .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_mosi(frm_mosi), .frm_miso(frm_miso), .frm_bits(frm_bits), .frm_cs(frm_cs),
        .frm_ovf(frm_ovf), .frm_err(frm_err), .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master model; sclk half period is 4 clk. Data changes one clk after the
    // shifting edge in cpha=1 modes, like a real slave/master output delay.
    task automatic spi_frame(input logic dpol, input logic dpha, input logic [NUM_CS-1:0] csv,
                             input int nbits, input logic [159:0] mo, input logic [159:0] mi,
                             input logic start_sclk, input logic release_cs);
        @(negedge clk);
        sclk = start_sclk;
        mosi = 1'b0;
        miso = 1'b0;
        cs_n = csv;
        repeat (4) @(negedge clk);
        if (sclk != dpol) begin
            sclk = dpol;
            repeat (4) @(negedge clk);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!dpha) begin
                mosi = mo[i];
                miso = mi[i];
                repeat (4) @(negedge clk);
                sclk = ~dpol;
                repeat (4) @(negedge clk);
                sclk = dpol;
            end else begin
                sclk = ~dpol;
                @(negedge clk);
                mosi = mo[i];
                miso = mi[i];
                repeat (3) @(negedge clk);
                sclk = dpol;
                repeat (4) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        if (release_cs) cs_n = '1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!frm_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 160'(frm_valid), 160'(1'b1));
    endtask

    task automatic accept();
        @(negedge clk);
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
        check("valid_after_accept", 160'(frm_valid), 160'(1'b0));
    endtask

    typedef struct {
        logic          cpol, cpha, dpol, dpha;
        logic [7:0]    cs_n;
        int            nbits;
        logic [159:0]  mo, mi;
        logic          ssclk;
        logic [127:0]  emo, emi;
        int            ebits;
        logic [7:0]    ecs;
        logic          eovf, eerr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFB, 8,   160'hA5, 160'h3C, 1'b0,
                    128'hA5, 128'h3C, 8, 8'h04, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 16,  160'hBEEF, 160'hBEEF, 1'b0,
                    128'hBEEF, 128'hBEEF, 16, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hFE, 16,  160'hBEEF, 160'hBEEF, 1'b1,
                    128'hBEEF, 128'hBEEF, 16, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 16,  160'hBEEF, 160'hBEEF, 1'b1,
                    128'hBEEF, 128'hBEEF, 16, 8'h01, 1'b0, 1'b0};
        // Sniffer in mode 0, master in mode 1: each leading edge sees the previous bit.
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 16,  160'hBEEF, 160'hBEEF, 1'b0,
                    128'h5F77, 128'h5F77, 16, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hEF, 130,
                    {32'h0, 2'b11, 128'h0123456789ABCDEF_FEDCBA9876543210},
                    {32'h0, 2'b01, 128'hDEADBEEFCAFEF00D_1122334455667788}, 1'b0,
                    128'h0123456789ABCDEF_FEDCBA9876543210,
                    128'hDEADBEEFCAFEF00D_1122334455667788, 128, 8'h10, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFC, 8,   160'h5A, 160'h81, 1'b0,
                    128'h5A, 128'h81, 8, 8'h03, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 8,   160'hC3, 160'h18, 1'b1,
                    128'hC3, 128'h18, 8, 8'h80, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_valid", 160'(frm_valid), 160'(1'b0));
        check("rst_bits",  160'(frm_bits),  160'(0));
        check("rst_mosi",  160'(frm_mosi),  160'(0));
        check("rst_drop",  160'(drop_cnt),  160'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            cpol = vecs[v].cpol;
            cpha = vecs[v].cpha;
            spi_frame(vecs[v].dpol, vecs[v].dpha, vecs[v].cs_n, vecs[v].nbits,
                      vecs[v].mo, vecs[v].mi, vecs[v].ssclk, 1'b1);
            wait_valid($sformatf("v%0d_valid", v));
            check($sformatf("v%0d_mosi", v), 160'(frm_mosi), 160'(vecs[v].emo));
            check($sformatf("v%0d_miso", v), 160'(frm_miso), 160'(vecs[v].emi));
            check($sformatf("v%0d_bits", v), 160'(frm_bits), 160'(vecs[v].ebits));
            check($sformatf("v%0d_cs",   v), 160'(frm_cs),   160'(vecs[v].ecs));
            check($sformatf("v%0d_ovf",  v), 160'(frm_ovf),  160'(vecs[v].eovf));
            check($sformatf("v%0d_err",  v), 160'(frm_err),  160'(vecs[v].eerr));
            accept();
        end

        // CS pulse with no clocks is discarded silently.
        cpol = 1'b0;
        cpha = 1'b0;
        spi_frame(1'b0, 1'b0, 8'hFD, 0, 160'h0, 160'h0, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        check("empty_no_valid", 160'(frm_valid), 160'(1'b0));
        check("empty_no_drop",  160'(drop_cnt),  160'(0));

        // Back-pressure: first frame held, next two dropped.
        spi_frame(1'b0, 1'b0, 8'hFE, 8, 160'h11, 160'hE1, 1'b0, 1'b1);
        wait_valid("bp_valid");
        spi_frame(1'b0, 1'b0, 8'hFE, 8, 160'h22, 160'hE2, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("bp_hold_mosi", 160'(frm_mosi), 160'h11);
        check("bp_drop1",     160'(drop_cnt), 160'(1));
        spi_frame(1'b0, 1'b0, 8'hFE, 8, 160'h33, 160'hE3, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("bp_still_valid", 160'(frm_valid), 160'(1'b1));
        check("bp_hold_mosi2",  160'(frm_mosi),  160'h11);
        check("bp_hold_miso2",  160'(frm_miso),  160'hE1);
        check("bp_drop2",       160'(drop_cnt),  160'(2));
        accept();

        // Reset mid-frame after 5 bits aborts the frame.
        spi_frame(1'b0, 1'b0, 8'hFE, 5, 160'h1F, 160'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        cs_n  = '1;
        sclk  = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_valid", 160'(frm_valid), 160'(1'b0));
        check("mid_rst_drop",  160'(drop_cnt),  160'(0));
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_no_valid", 160'(frm_valid), 160'(1'b0));
        spi_frame(1'b0, 1'b0, 8'hF7, 8, 160'h96, 160'h69, 1'b0, 1'b1);
        wait_valid("post_rst_valid");
        check("post_rst_bits", 160'(frm_bits), 160'(8));
        check("post_rst_mosi", 160'(frm_mosi), 160'h96);
        check("post_rst_miso", 160'(frm_miso), 160'h69);
        check("post_rst_cs",   160'(frm_cs),   160'h08);
        check("post_rst_err",  160'(frm_err),  160'(1'b0));
        accept();
        repeat (12) @(negedge clk);
        check("no_extra_frame", 160'(frm_valid), 160'(1'b0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_capture.md
Name: spi_frame_capture

Overview:
- Synthesizable passive SPI frame sniffer for the SPI/APB subsystem; sits on the SPI pins alongside the controller, never drives them.
- Oversamples SCLK, CS_N, MOSI and MISO on the system clock and captures each chip-select frame using the sample edge defined by the CPOL/CPHA mode.
- Presents each completed frame (MOSI and MISO data, bit count, active CS) on a valid/ready output port, with overflow, drop and protocol-error reporting.

Parameters:
- NUM_CS, 8, number of active-low chip-select lines.
- MAX_BITS, 128, capture depth per frame, in bits.
- CNT_W, $clog2(MAX_BITS+1), width of the bit counter.

Ports:
- clk  in  1  system clock; frequency must be at least 4x the SCLK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  NUM_CS  chip selects, active low, asynchronous.
- mosi  in  1  SPI MOSI, asynchronous.
- miso  in  1  SPI MISO, asynchronous.
- cpol  in  1  clock polarity; static, latched at frame start.
- cpha  in  1  clock phase; static, latched at frame start.
- frm_valid  out  1  captured frame available.
- frm_ready  in  1  consumer accepts the frame.
- frm_mosi  out  MAX_BITS  MOSI bits; last sampled bit at bit 0.
- frm_miso  out  MAX_BITS  MISO bits; same alignment as frm_mosi.
- frm_bits  out  CNT_W  number of valid bits, saturating at MAX_BITS.
- frm_cs  out  NUM_CS  active-high copy of the CS lines asserted at frame start.
- frm_ovf  out  1  frame contained more than MAX_BITS sample edges.
- frm_err  out  1  more than one CS asserted, or SCLK not idle at CPOL when the frame started.
- drop_cnt  out  8  frames lost because the output was still occupied; saturates at 255.

Behaviour:
- Synchronization: sclk, cs_n, mosi and miso each pass through a 2-flop synchronizer. All logic below operates on the synchronized copies.
- Edge detection: one extra flop on synced sclk. Rising edge = s & ~s_d; falling edge = ~s & s_d.
- Sample edge selection:
  - leading edge = rising when cpol=0, falling when cpol=1.
  - sample on the leading edge when cpha=0, on the trailing edge when cpha=1.
- FSM states:
  - IDLE -> ACTIVE when any synced cs_n bit is low. On entry: latch cpol/cpha, latch ~cs_n into the frame cs register, clear shift registers and counter, set err if popcount(~cs_n)>1 or sclk!=cpol.
  - ACTIVE: on each sample edge, shift {reg,mosi} and {reg,miso} in LSB-first position and increment the counter. The counter saturates at MAX_BITS; further edges still shift but set ovf.
  - ACTIVE -> DONE when all synced cs_n bits are high. A sample edge in that same cycle is captured first.
  - DONE -> IDLE in one cycle. If counter==0, discard the frame with no output and no drop. Otherwise push to the output register, or, if frm_valid && !frm_ready, drop it and increment drop_cnt.
  - A CS change while ACTIVE (different line low, none released to all-high) does not end the frame; it sets err.
- Output handshake:
  - frm_valid rises 1 clk after DONE; total 4 clk from the raw cs_n all-high.
  - frm_valid and all frm_* outputs hold stable until a clk with frm_valid && frm_ready.
  - A push in the same cycle as acceptance is allowed: valid stays high with the new data.
- Reset: all outputs and registers clear to 0, FSM to IDLE, synchronizers to idle values (sclk 0, cs_n all-ones). Reset mid-frame aborts the frame with no output.
- Frames shorter than MAX_BITS: upper bits of frm_mosi/frm_miso are 0.

Test Plan:
- Mode 0, cs_n[2] low, 8 clocks, MOSI 0xA5, MISO 0x3C -> frm_valid with frm_mosi=0xA5, frm_miso=0x3C, frm_bits=8, frm_cs=0x04, frm_ovf=0, frm_err=0.
- Modes 1, 2, 3 with the same 16-bit word 0xBEEF on both lines -> identical frm_mosi=0xBEEF, frm_bits=16 in every mode; with cpha mismatched at the driver, the data differs.
- 130 clocks with MAX_BITS=128 -> frm_bits=128, frm_ovf=1, frm_mosi holds the last 128 bits.
- frm_ready held low across 3 frames -> first frame held stable, drop_cnt=2; raise ready -> accepted, valid drops.
- cs_n=0xFC (two lines) or sclk=1 at start with cpol=0 -> frm_err=1. CS pulse with no clocks -> no frm_valid.
- rst_n asserted mid-frame after 5 bits, then a clean 8-bit frame -> only the 8-bit frame is reported, frm_bits=8.
